reg_bank_sequencer: RTL and testbench

Multi-cycle control sequencer directly upstream of the general-purpose register bank. Accepts one decoded instruction at a time over a valid/ready handshake. Drives the bank's per-register `load`, `out0_en` and `out1_en` strobes, the ALU operation select and the write-bus source selects, so that each instruction reads its operands, writes its result and retires in a fixed number of cycles.

---
 rtl/reg_bank_sequencer.sv | 139 +++++++++++++
 tb/tb_reg_bank_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_sequencer.sv
// Three-state control sequencer driving the register bank strobes, ALU select and bus sources.
// Optional REGSEQ_ZERO_REG_EN makes register 0 a hardwired zero (no write strobe, bus undriven).
module reg_bank_sequencer #(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned DATA_BITS = 8,
    localparam int unsigned IDX_BITS = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [2:0]           op,
    input  logic [IDX_BITS-1:0]  rd,
    input  logic [IDX_BITS-1:0]  rs_a,
    input  logic [IDX_BITS-1:0]  rs_b,
    input  logic [DATA_BITS-1:0] imm,
    output logic [NUM_REGS-1:0]  out0_en,
    output logic [NUM_REGS-1:0]  out1_en,
    output logic [NUM_REGS-1:0]  load,
    output logic [2:0]           alu_op,
    output logic                 alu_out_en,
    output logic                 imm_en,
    output logic [DATA_BITS-1:0] imm_out,
    output logic                 retired
);

    localparam logic [2:0] OpLdi   = 3'b001;
    localparam logic [2:0] OpMov   = 3'b010;
    localparam logic [2:0] OpAdd   = 3'b011;
    localparam logic [2:0] AluPass = 3'b000;

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    state_e               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [IDX_BITS-1:0]  rd_q, rd_d, rs_a_q, rs_a_d, rs_b_q, rs_b_d;
    logic [DATA_BITS-1:0] imm_q, imm_d;

    logic                 accept;
    logic                 uses_src, is_alu, wr_ok;
    logic                 ready_d, alu_out_en_d, imm_en_d, retired_d;
    logic [NUM_REGS-1:0]  out0_d, out1_d, load_d;
    logic [2:0]           alu_op_d;
    logic [DATA_BITS-1:0] imm_out_d;

    always_comb begin
        accept = instr_valid && (state_q == StIdle);
        op_d   = accept ? op   : op_q;
        rd_d   = accept ? rd   : rd_q;
        rs_a_d = accept ? rs_a : rs_a_q;
        rs_b_d = accept ? rs_b : rs_b_q;
        imm_d  = accept ? imm  : imm_q;

        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = (op >= OpMov) ? StRead : StWrite;
            StRead:  state_d = StWrite;
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state and next fields, then registered.
    always_comb begin
        uses_src     = (op_d >= OpMov);
        is_alu       = (op_d >= OpAdd);
`ifdef REGSEQ_ZERO_REG_EN
        wr_ok        = (rd_d != '0);
`else
        wr_ok        = 1'b1;
`endif
        ready_d      = (state_d == StIdle);
        out0_d       = '0;
        out1_d       = '0;
        load_d       = '0;
        alu_op_d     = AluPass;
        alu_out_en_d = 1'b0;
        imm_en_d     = 1'b0;
        imm_out_d    = '0;
        retired_d    = 1'b0;

        if (state_d != StIdle && uses_src) begin
            out0_d[rs_a_d] = 1'b1;
            if (is_alu) begin
                out1_d[rs_b_d] = 1'b1;
                alu_op_d       = op_d - 3'd2;
            end
        end

        if (state_d == StWrite) begin
            retired_d = 1'b1;
            if (op_d == OpLdi) begin
                imm_out_d      = imm_d;
                imm_en_d       = wr_ok;
                load_d[rd_d]   = wr_ok;
            end else if (uses_src) begin
                alu_out_en_d   = wr_ok;
                load_d[rd_d]   = wr_ok;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= '0;
            rd_q        <= '0;
            rs_a_q      <= '0;
            rs_b_q      <= '0;
            imm_q       <= '0;
            instr_ready <= 1'b1;
            out0_en     <= '0;
            out1_en     <= '0;
            load        <= '0;
            alu_op      <= AluPass;
            alu_out_en  <= 1'b0;
            imm_en      <= 1'b0;
            imm_out     <= '0;
            retired     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            rs_a_q      <= rs_a_d;
            rs_b_q      <= rs_b_d;
            imm_q       <= imm_d;
            instr_ready <= ready_d;
            out0_en     <= out0_d;
            out1_en     <= out1_d;
            load        <= load_d;
            alu_op      <= alu_op_d;
            alu_out_en  <= alu_out_en_d;
            imm_en      <= imm_en_d;
            imm_out     <= imm_out_d;
            retired     <= retired_d;
        end
    end

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Directed plus randomized bench for reg_bank_sequencer, checked against a per-cycle
// expectation built from the instruction's phase sequence.
module tb_reg_bank_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  op;
    logic [3:0]  rd, rs_a, rs_b;
    logic [7:0]  imm;
    logic [15:0] out0_en, out1_en, load;
    logic [2:0]  alu_op;
    logic        alu_out_en, imm_en, retired;
    logic [7:0]  imm_out;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    reg_bank_sequencer #(.NUM_REGS(16), .DATA_BITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .op          (op),
        .rd          (rd),
        .rs_a        (rs_a),
        .rs_b        (rs_b),
        .imm         (imm),
        .out0_en     (out0_en),
        .out1_en     (out1_en),
        .load        (load),
        .alu_op      (alu_op),
        .alu_out_en  (alu_out_en),
        .imm_en      (imm_en),
        .imm_out     (imm_out),
        .retired     (retired)
    );

    typedef struct packed {
        logic        ready;
        logic [15:0] out0;
        logic [15:0] out1;
        logic [15:0] ld;
        logic [2:0]  alu;
        logic        alu_en;
        logic        imm_en;
        logic [7:0]  imm_out;
        logic        retired;
    } frame_t;

`ifdef REGSEQ_ZERO_REG_EN
    localparam bit ZeroReg = 1'b1;
`else
    localparam bit ZeroReg = 1'b0;
`endif

    // phase: 0 idle, 1 read, 2 write. Opcodes: 0 NOP, 1 LDI, 2 MOV, 3..7 ADD/SUB/AND/OR/XOR.
    function automatic frame_t expect_frame(int phase, logic [2:0] f_op, logic [3:0] f_rd,
                                            logic [3:0] f_ra, logic [3:0] f_rb,
                                            logic [7:0] f_imm);
        frame_t f;
        bit     wr;
        f = '0;
        f.ready = (phase == 0);
        if (phase == 0) return f;
        if (f_op >= 3'd2) f.out0 = 16'h0001 << f_ra;
        if (f_op >= 3'd3) begin
            f.out1 = 16'h0001 << f_rb;
            f.alu  = f_op - 3'd2;
        end
        if (phase == 2) begin
            f.retired = 1'b1;
            wr = !(ZeroReg && f_rd == 4'd0);
            if (f_op == 3'd1) begin
                f.imm_out = f_imm;
                f.imm_en  = wr;
                f.ld      = wr ? (16'h0001 << f_rd) : 16'h0000;
            end else if (f_op >= 3'd2) begin
                f.alu_en  = wr;
                f.ld      = wr ? (16'h0001 << f_rd) : 16'h0000;
            end
        end
        return f;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_frame(string ctx, frame_t e);
        chk({ctx, ".ready"},   32'(instr_ready), 32'(e.ready));
        chk({ctx, ".out0"},    32'(out0_en),     32'(e.out0));
        chk({ctx, ".out1"},    32'(out1_en),     32'(e.out1));
        chk({ctx, ".load"},    32'(load),        32'(e.ld));
        chk({ctx, ".alu_op"},  32'(alu_op),      32'(e.alu));
        chk({ctx, ".alu_en"},  32'(alu_out_en),  32'(e.alu_en));
        chk({ctx, ".imm_en"},  32'(imm_en),      32'(e.imm_en));
        chk({ctx, ".imm_out"}, 32'(imm_out),     32'(e.imm_out));
        chk({ctx, ".retired"}, 32'(retired),     32'(e.retired));
    endtask

    task automatic scramble_fields();
        op   = 3'($urandom);
        rd   = 4'($urandom);
        rs_a = 4'($urandom);
        rs_b = 4'($urandom);
        imm  = 8'($urandom);
    endtask

    // Called at a negedge of an idle cycle. mode 0: valid dropped after accept;
    // mode 1: valid held (caller must issue next); mode 2: valid pulsed during first busy cycle.
    task automatic run_instr(string name, logic [2:0] f_op, logic [3:0] f_rd, logic [3:0] f_ra,
                             logic [3:0] f_rb, logic [7:0] f_imm, int mode);
        int nph;
        nph = (f_op >= 3'd2) ? 2 : 1;
        op = f_op; rd = f_rd; rs_a = f_ra; rs_b = f_rb; imm = f_imm;
        instr_valid = 1'b1;
        for (int p = 0; p < nph; p++) begin
            @(negedge clk);
            instr_valid = (mode == 1) || (mode == 2 && p == 0);
            scramble_fields();
            check_frame($sformatf("%s.ph%0d", name, p),
                        expect_frame((nph == 2 && p == 0) ? 1 : 2, f_op, f_rd, f_ra, f_rb, f_imm));
        end
        @(negedge clk);
        if (mode != 1) instr_valid = 1'b0;
        check_frame({name, ".idle"}, expect_frame(0, f_op, f_rd, f_ra, f_rb, f_imm));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t idle_f;
        idle_f = expect_frame(0, 3'd0, 4'd0, 4'd0, 4'd0, 8'd0);
        reset = 1'b1;
        instr_valid = 1'b0;
        op = 3'd0; rd = 4'd0; rs_a = 4'd0; rs_b = 4'd0; imm = 8'd0;
        repeat (2) @(negedge clk);
        check_frame("reset", idle_f);
        reset = 1'b0;
        @(negedge clk);
        check_frame("post_reset", idle_f);

        run_instr("ldi_r3",  3'd1, 4'd3, 4'd0, 4'd0, 8'h5A, 0);
        run_instr("add",     3'd3, 4'd2, 4'd3, 4'd4, 8'h00, 0);
        run_instr("mov_r5",  3'd2, 4'd5, 4'd5, 4'd9, 8'h00, 1);
        run_instr("sub_b2b", 3'd4, 4'd7, 4'd1, 4'd1, 8'h00, 0);

        // Reset during the READ cycle of an XOR drops the write.
        op = 3'd7; rd = 4'd6; rs_a = 4'd2; rs_b = 4'd8; imm = 8'd0;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check_frame("xor.read", expect_frame(1, 3'd7, 4'd6, 4'd2, 4'd8, 8'd0));
        reset = 1'b1;
        @(negedge clk);
        check_frame("xor.reset", idle_f);
        reset = 1'b0;
        @(negedge clk);
        check_frame("xor.after", idle_f);

        run_instr("nop",     3'd0, 4'd4, 4'd1, 4'd2, 8'h33, 0);
        run_instr("and_tog", 3'd5, 4'd9, 4'd10, 4'd11, 8'h00, 2);
        run_instr("ldi_r0",  3'd1, 4'd0, 4'd0, 4'd0, 8'hFF, 0);
        run_instr("or_r0",   3'd6, 4'd0, 4'd15, 4'd0, 8'h00, 0);

        for (int i = 0; i < 40; i++) begin
            int mode;
            mode = (i == 39) ? 0 : int'($urandom_range(0, 2));
            run_instr($sformatf("rnd%0d", i), 3'($urandom), 4'($urandom), 4'($urandom),
                      4'($urandom), 8'($urandom), mode);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
